mandala_engine: RTL and testbench

Parametrised, pipelined successor to the fixed 8-ring mandala renderer. Consumes pixel coordinates and sync signals from hvsync_generator and produces 6-bit RGB (2:2:2) with syncs delayed to match. Adds configurable ring count and width, four selectable pattern modes, a programmable animation prescaler, freeze control and a frame tick. Sits between hvsync_generator and the top-level uo_out packing.

---
 rtl/mandala_pkg.sv | 19 +
 rtl/mandala_radius.sv | 56 +++++
 rtl/mandala_engine.sv | 158 +++++++++++++++
 tb/tb_mandala_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mandala_pkg.sv
// Shared constants and helpers for the mandala renderer: mode encodings,
// pipeline depth and the per-ring colour tint.
package mandala_pkg;

    localparam logic [1:0] MODE_PETAL  = 2'd0;
    localparam logic [1:0] MODE_RING   = 2'd1;
    localparam logic [1:0] MODE_SPIRAL = 2'd2;
    localparam logic [1:0] MODE_SOLID  = 2'd3;

    localparam int PIPE_LAT = 3;
    localparam int TINT_MUL = 21;
    localparam int TINT_OFS = 48;

    // Ring tint (L*21 + 48) mod 64; 6-bit arithmetic gives the modulo for free.
    function automatic logic [5:0] tint(input logic [5:0] layer);
        return layer * 6'(TINT_MUL) + 6'(TINT_OFS);
    endfunction

endpackage

// File: rtl/mandala_radius.sv
// Stages 1-2 of the mandala pipeline: absolute deltas from the centre (S1, 1 cycle)
// and octagonal radius max+min/2 (S2, 1 more cycle); free-running, no backpressure.
module mandala_radius
    import mandala_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int H_CENTER = 320,
    parameter int V_CENTER = 240
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] i_hpos,
    input  logic [COORD_W-1:0] i_vpos,
    output logic [COORD_W-1:0] o_dx,
    output logic [COORD_W-1:0] o_dy,
    output logic [COORD_W:0]   o_radius
);

    localparam logic [COORD_W-1:0] LP_HC = COORD_W'(H_CENTER);
    localparam logic [COORD_W-1:0] LP_VC = COORD_W'(V_CENTER);

    logic [COORD_W-1:0] w_dx_abs;
    logic [COORD_W-1:0] w_dy_abs;
    logic [COORD_W-1:0] w_max;
    logic [COORD_W-1:0] w_min;
    logic [COORD_W:0]   w_radius;

    logic [COORD_W-1:0] r_dx;
    logic [COORD_W-1:0] r_dy;
    logic [COORD_W:0]   r_radius;

    assign w_dx_abs = (i_hpos >= LP_HC) ? (i_hpos - LP_HC) : (LP_HC - i_hpos);
    assign w_dy_abs = (i_vpos >= LP_VC) ? (i_vpos - LP_VC) : (LP_VC - i_vpos);

    assign w_max = (r_dx >= r_dy) ? r_dx : r_dy;
    assign w_min = (r_dx >= r_dy) ? r_dy : r_dx;
    // One extra bit of headroom: max + min/2 never exceeds 1.5 * max.
    assign w_radius = {1'b0, w_max} + {2'b00, w_min[COORD_W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dx     <= '0;
            r_dy     <= '0;
            r_radius <= '0;
        end else begin
            r_dx     <= w_dx_abs;
            r_dy     <= w_dy_abs;
            r_radius <= w_radius;
        end
    end

    assign o_dx     = r_dx;
    assign o_dy     = r_dy;
    assign o_radius = r_radius;

endmodule

// File: rtl/mandala_engine.sv
// Pipelined mandala renderer: coords+syncs in, 2:2:2 RGB out; PINGPONG_EN makes phase bounce.
// Latency 3 cycles (pixel and syncs alike); no backpressure, one pixel per clock.
module mandala_engine
    import mandala_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int H_CENTER   = 320,
    parameter int V_CENTER   = 240,
    parameter int N_LAYERS   = 8,
    parameter int RING_SHIFT = 6,
    parameter int PHASE_W    = 8
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic               display_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [1:0]         mode,
    input  logic [2:0]         speed,
    input  logic               freeze,
    output logic [5:0]         rgb,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               frame_tick,
    output logic [PHASE_W-1:0] phase
);

    localparam logic [COORD_W:0] LP_N_LAYERS = (COORD_W+1)'(N_LAYERS);

    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic [COORD_W:0]   w_radius;

    mandala_radius #(
        .COORD_W  (COORD_W),
        .H_CENTER (H_CENTER),
        .V_CENTER (V_CENTER)
    ) u_radius (
        .clk      (clk),
        .rst      (reset),
        .i_hpos   (hpos),
        .i_vpos   (vpos),
        .o_dx     (w_dx),
        .o_dy     (w_dy),
        .o_radius (w_radius)
    );

    logic               r_vsync_prev;
    logic               r_frame_tick;
    logic [2:0]         r_frame_div;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic               w_vs_edge;
    logic               w_frame_en;
    logic               w_advance;

    assign w_vs_edge  = vsync_in & ~r_vsync_prev;
    assign w_frame_en = w_vs_edge & ~freeze;
    // >= rather than == so a speed lowered mid-count still releases promptly.
    assign w_advance  = w_frame_en & (r_frame_div >= speed);

`ifdef PINGPONG_EN
    logic r_dir;
    logic w_hit_end;

    assign w_phase_next = r_dir ? (r_phase - PHASE_W'(1)) : (r_phase + PHASE_W'(1));
    assign w_hit_end    = r_dir ? (w_phase_next == '0) : (w_phase_next == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dir <= 1'b0;
        end else if (w_advance && w_hit_end) begin
            r_dir <= ~r_dir;
        end
    end
`else
    assign w_phase_next = r_phase + PHASE_W'(1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_prev <= 1'b0;
            r_frame_tick <= 1'b0;
            r_frame_div  <= '0;
            r_phase      <= '0;
        end else begin
            r_vsync_prev <= vsync_in;
            r_frame_tick <= w_vs_edge;
            if (w_frame_en) begin
                r_frame_div <= w_advance ? 3'd0 : (r_frame_div + 3'd1);
            end
            if (w_advance) begin
                r_phase <= w_phase_next;
            end
        end
    end

    logic [2:0] r_hs_d;
    logic [2:0] r_vs_d;
    logic [1:0] r_de_d;
    logic [7:0] r_ang;
    logic [1:0] r_mode_s2;
    logic [5:0] r_rgb;

    logic [COORD_W:0] w_layer;
    logic [2:0]       w_k;
    logic [2:0]       w_petal_idx;
    logic [2:0]       w_spiral_idx;
    logic             w_lit;
    logic             w_valid;
    logic [5:0]       w_colour;
    logic             w_unused;

    assign w_layer      = w_radius >> RING_SHIFT;
    assign w_k          = w_layer[2:0];
    assign w_petal_idx  = w_k + 3'd3;
    assign w_spiral_idx = w_radius[5:3] + w_k;
    assign w_valid      = r_de_d[1] & (w_layer < LP_N_LAYERS);
    assign w_colour     = r_phase[7:2] + tint(w_layer[5:0]);
    assign w_unused     = ^{w_dx, w_dy, w_radius[2:0], r_phase};

    always_comb begin
        w_lit = 1'b1;
        case (r_mode_s2)
            MODE_PETAL:  w_lit = r_ang[w_k] ^ r_ang[w_petal_idx];
            MODE_RING:   w_lit = w_layer[0] ^ r_ang[7];
            MODE_SPIRAL: w_lit = r_ang[w_spiral_idx];
            default:     w_lit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_d    <= '0;
            r_vs_d    <= '0;
            r_de_d    <= '0;
            r_ang     <= '0;
            r_mode_s2 <= MODE_PETAL;
            r_rgb     <= '0;
        end else begin
            r_hs_d    <= {r_hs_d[1:0], hsync_in};
            r_vs_d    <= {r_vs_d[1:0], vsync_in};
            r_de_d    <= {r_de_d[0], display_on};
            r_ang     <= (w_dx[7:0] ^ w_dy[7:0]) + r_phase[7:0];
            r_mode_s2 <= mode;
            r_rgb     <= (w_valid & w_lit) ? w_colour : 6'd0;
        end
    end

    assign rgb        = r_rgb;
    assign hsync_out  = r_hs_d[2];
    assign vsync_out  = r_vs_d[2];
    assign frame_tick = r_frame_tick;
    assign phase      = r_phase;

endmodule

// File: tb/tb_mandala_engine.sv
// Self-checking bench for mandala_engine: vector table, frame/phase sequences,
// randomized pixels against a plain-arithmetic reference, and async reset.
module tb_mandala_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       display_on, hsync_in, vsync_in, freeze;
    logic [1:0] mode;
    logic [2:0] speed;
    logic [5:0] rgb, rgb4;
    logic       hsync_out, vsync_out, frame_tick;
    logic       hs4, vs4, ft4;
    logic [7:0] phase, ph4;

    int total = 0;
    int bad   = 0;
    int n_ticks = 0;
    int m_phase = 0, m_div = 0, m_dir = 0;

    always #5 clk = ~clk;

    mandala_engine u_dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .speed(speed), .freeze(freeze),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_tick(frame_tick), .phase(phase)
    );

    mandala_engine #(.N_LAYERS(4)) u_dut4 (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .speed(speed), .freeze(freeze),
        .rgb(rgb4), .hsync_out(hs4), .vsync_out(vs4), .frame_tick(ft4), .phase(ph4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference pixel colour straight from the rendering rules.
    function automatic int ref_rgb(int h, int v, int de, int md, int ph, int nl);
        int dx, dy, mx, mn, r, L, ang, k, lit;
        dx = (h >= 320) ? h - 320 : 320 - h;
        dy = (v >= 240) ? v - 240 : 240 - v;
        mx = (dx > dy) ? dx : dy;
        mn = (dx > dy) ? dy : dx;
        r  = mx + mn / 2;
        L  = r / 64;
        ang = (((dx % 256) ^ (dy % 256)) + ph) % 256;
        k  = L % 8;
        case (md)
            0: lit = ((ang >> k) & 1) ^ ((ang >> ((k + 3) % 8)) & 1);
            1: lit = (L % 2) ^ ((ang >> 7) & 1);
            2: lit = (ang >> ((((r / 8) % 8) + k) % 8)) & 1;
            default: lit = 1;
        endcase
        if (de == 0 || L >= nl || lit == 0) return 0;
        return (((ph / 4) % 64) + L * 21 + 48) % 64;
    endfunction

    task automatic model_edge();
        if (!freeze) begin
            if (m_div >= speed) begin
                m_div = 0;
`ifdef PINGPONG_EN
                if (m_dir == 0) begin
                    m_phase++;
                    if (m_phase == 255) m_dir = 1;
                end else begin
                    m_phase--;
                    if (m_phase == 0) m_dir = 0;
                end
`else
                m_phase = (m_phase + 1) % 256;
`endif
            end else begin
                m_div++;
            end
        end
    endtask

    // One vsync pulse: high for a cycle, low for a cycle; ticks are counted.
    task automatic frame_edge();
        vsync_in = 1'b1;
        @(posedge clk); #1;
        model_edge();
        if (frame_tick) n_ticks++;
        vsync_in = 1'b0;
        @(posedge clk); #1;
        if (frame_tick) n_ticks++;
    endtask

    typedef struct {
        int h; int v; int de; int md; int e8; int e4;
    } vec_t;

    vec_t tbl[10];
    int hq[300], vq[300], dq[300], mq[300], hsq[300];
    int hh[40], vh[40];
    int n, e;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hpos = 0; vpos = 0; display_on = 0; hsync_in = 0; vsync_in = 0;
        mode = 2'd3; speed = 3'd0; freeze = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rgb", rgb, 0);
        chk("reset_hsync", hsync_out, 0);
        chk("reset_vsync", vsync_out, 0);
        chk("reset_tick", frame_tick, 0);
        chk("reset_phase", phase, 0);
        reset = 1'b0;

        tbl[0] = '{320, 240, 1, 3, 'h30, 'h30};
        tbl[1] = '{384, 240, 1, 3, 'h05, 'h05};
        tbl[2] = '{  0,   0, 1, 3, 'h2E, 0};
        tbl[3] = '{320, 240, 0, 3, 0, 0};
        tbl[4] = '{384, 240, 1, 1, 'h05, 'h05};
        tbl[5] = '{330, 240, 1, 0, 'h30, 'h30};
        tbl[6] = '{330, 240, 1, 2, 'h30, 'h30};
        tbl[7] = '{384, 240, 1, 0, 0, 0};
        tbl[8] = '{320, 240, 1, 0, 0, 0};
        tbl[9] = '{384, 240, 1, 2, 0, 0};
        for (int i = 0; i < 10; i++) begin
            hpos = 10'(tbl[i].h); vpos = 10'(tbl[i].v);
            display_on = tbl[i].de[0]; mode = 2'(tbl[i].md);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rgb", i), rgb, tbl[i].e8);
            chk($sformatf("vec%0d_rgb4", i), rgb4, tbl[i].e4);
        end

        // Sync delay with phase frozen.
        freeze = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i >= 3) begin
                chk("hsync_delay", hsync_out, hh[i-3]);
                chk("vsync_delay", vsync_out, vh[i-3]);
            end
            hh[i] = int'($urandom_range(0, 1)); vh[i] = int'($urandom_range(0, 1));
            hsync_in = hh[i][0]; vsync_in = vh[i][0];
            @(posedge clk); #1;
        end
        hsync_in = 0; vsync_in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("frozen_phase", phase, 0);

        freeze = 1'b0; speed = 3'd2; n_ticks = 0;
        repeat (9) frame_edge();
        chk("speed2_phase", phase, 3);
        chk("speed2_ticks", n_ticks, 9);
        freeze = 1'b1;
        repeat (4) frame_edge();
        chk("freeze_phase", phase, 3);
        chk("freeze_ticks", n_ticks, 13);

        freeze = 1'b0; speed = 3'd3;
        repeat (2) frame_edge();
        chk("div_hold_phase", phase, 3);
        speed = 3'd1;
        frame_edge();
        chk("speed_drop_phase", phase, 4);

        speed = 3'd0;
        repeat (250) frame_edge();
        chk("phase_254", phase, 254);
        frame_edge(); chk("wrap_a", phase, 255);
`ifdef PINGPONG_EN
        frame_edge(); chk("wrap_b", phase, 254);
        frame_edge(); chk("wrap_c", phase, 253);
`else
        frame_edge(); chk("wrap_b", phase, 0);
        frame_edge(); chk("wrap_c", phase, 1);
`endif
        n = int'($urandom_range(1, 200));
        repeat (n) frame_edge();
        chk("model_phase", phase, m_phase);

        // Randomized pixels; mode may change every cycle.
        for (int i = 0; i < 300; i++) begin
            if (i >= 3) begin
                e = ref_rgb(hq[i-3], vq[i-3], dq[i-3], mq[i-2], m_phase, 8);
                chk("rand_rgb", rgb, e);
                e = ref_rgb(hq[i-3], vq[i-3], dq[i-3], mq[i-2], m_phase, 4);
                chk("rand_rgb4", rgb4, e);
                chk("rand_hsync", hsync_out, hsq[i-3]);
            end
            if ($urandom_range(0, 3) == 0) begin
                hq[i] = int'($urandom_range(0, 1023)); vq[i] = int'($urandom_range(0, 1023));
            end else begin
                hq[i] = int'($urandom_range(0, 639)); vq[i] = int'($urandom_range(0, 479));
            end
            dq[i] = ($urandom_range(0, 7) != 0) ? 1 : 0;
            mq[i] = int'($urandom_range(0, 3));
            hsq[i] = int'($urandom_range(0, 1));
            hpos = 10'(hq[i]); vpos = 10'(vq[i]); display_on = dq[i][0];
            mode = 2'(mq[i]); hsync_in = hsq[i][0];
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a line.
        hpos = 320; vpos = 240; display_on = 1; mode = 2'd3; hsync_in = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_rgb", rgb, ref_rgb(320, 240, 1, 3, m_phase, 8));
        #2;
        reset = 1'b1;
        #1;
        chk("async_rgb", rgb, 0);
        chk("async_hsync", hsync_out, 0);
        chk("async_vsync", vsync_out, 0);
        chk("async_phase", phase, 0);
        chk("async_tick", frame_tick, 0);
        #3;
        reset = 1'b0;
        m_phase = 0; m_div = 0; m_dir = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset_lat2_rgb", rgb, 0);
        chk("post_reset_lat2_hs", hsync_out, 0);
        @(posedge clk); #1;
        chk("post_reset_lat3_rgb", rgb, 'h30);
        chk("post_reset_lat3_hs", hsync_out, 1);
        chk("post_reset_rgb4", rgb4, 'h30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
